// File: rtl/nrisc_pkg.sv
// Shared types for the multi-cycle nRISC core: opcodes, FSM states,
// ALU selects and instruction field positions.
package nrisc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_ADDI = 3'b011,
      OP_LW   = 3'b100,
      OP_SW   = 3'b101,
      OP_BEQZ = 3'b110,
      OP_JR   = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_e;

   typedef enum logic [1:0] {
      ULA_ADD,
      ULA_SUB,
      ULA_AND,
      ULA_PASSB
   } ula_op_e;

   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int RA_MSB  = 4;
   localparam int RA_LSB  = 3;
   localparam int RB_MSB  = 2;
   localparam int RB_LSB  = 1;
   localparam int IMM_MSB = 2;
   localparam int IMM_LSB = 0;

   // BEQZ and JR route their operand through pass-B so the zero flag and PC source share one path
   function automatic ula_op_e ula_op_of(input opcode_e op);
      case (op)
         OP_ADD, OP_ADDI: return ULA_ADD;
         OP_SUB:          return ULA_SUB;
         OP_AND:          return ULA_AND;
         default:         return ULA_PASSB;
      endcase
   endfunction

endpackage

// File: rtl/nrisc_ula.sv
// Combinational ALU for the nRISC core: add, subtract, and, pass-B,
// plus a zero flag on the result. All arithmetic wraps modulo 2^DATA_W.
module nrisc_ula
   import nrisc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  ula_op_e           i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_y,
   output logic              o_zero
);

   always_comb begin
      case (i_op)
         ULA_ADD: o_y = i_a + i_b;
         ULA_SUB: o_y = i_a - i_b;
         ULA_AND: o_y = i_a & i_b;
         default: o_y = i_b;
      endcase
   end

   assign o_zero = (o_y == '0);

endmodule

// File: rtl/nrisc_multiciclo.sv
// Multi-cycle nRISC core: fetch/decode/execute/memory/writeback FSM with
// req/ready handshakes to separate instruction and data memories.
module nrisc_multiciclo
   import nrisc_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   input  logic              imem_ready,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic [ADDR_W-1:0] pc_o,
   output logic              retire
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_npc;
   logic [7:0]        r_ir;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_alu_out;
   logic [DATA_W-1:0] r_mdr;
   logic [DATA_W-1:0] r_rf [4];
   logic              r_imem_req;
   logic              r_dmem_req;
   logic              r_dmem_we;
   logic [ADDR_W-1:0] r_dmem_addr;
   logic [DATA_W-1:0] r_dmem_wdata;
   logic              r_retire;

   opcode_e           w_op;
   logic [1:0]        w_ra;
   logic [1:0]        w_rb;
   logic [2:0]        w_imm3;
   logic [DATA_W-1:0] w_sext_d;
   logic [ADDR_W-1:0] w_sext_a;
   logic [DATA_W-1:0] w_ula_b;
   logic [DATA_W-1:0] w_ula_y;
   logic              w_ula_zero;
   logic [ADDR_W-1:0] w_b_addr;

   assign w_op     = opcode_e'(r_ir[OP_MSB:OP_LSB]);
   assign w_ra     = r_ir[RA_MSB:RA_LSB];
   assign w_rb     = r_ir[RB_MSB:RB_LSB];
   assign w_imm3   = r_ir[IMM_MSB:IMM_LSB];
   assign w_sext_d = {{(DATA_W-3){w_imm3[2]}}, w_imm3};
   assign w_sext_a = {{(ADDR_W-3){w_imm3[2]}}, w_imm3};
   assign w_b_addr = ADDR_W'(r_b);

   // BEQZ tests A through pass-B; ADDI replaces B with the immediate
   assign w_ula_b = (w_op == OP_ADDI) ? w_sext_d :
                    (w_op == OP_BEQZ) ? r_a      : r_b;

   nrisc_ula #(
      .DATA_W (DATA_W)
   ) u_ula (
      .i_op   (ula_op_of(w_op)),
      .i_a    (r_a),
      .i_b    (w_ula_b),
      .o_y    (w_ula_y),
      .o_zero (w_ula_zero)
   );

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_npc        <= '0;
         r_ir         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_alu_out    <= '0;
         r_mdr        <= '0;
         for (int i = 0; i < 4; i++) r_rf[i] <= '0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_wdata <= '0;
         r_retire     <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            // req is raised on entry, so a zero-wait fetch completes in one cycle
            S_FETCH: begin
               if (r_imem_req && imem_ready) begin
                  r_ir       <= imem_rdata;
                  r_npc      <= r_pc + ADDR_W'(1);
                  r_imem_req <= 1'b0;
                  r_state    <= S_DECODE;
               end else begin
                  r_imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               r_a     <= r_rf[w_ra];
               r_b     <= r_rf[w_rb];
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               case (w_op)
                  OP_LW, OP_SW: begin
                     r_dmem_req   <= 1'b1;
                     r_dmem_we    <= (w_op == OP_SW);
                     r_dmem_addr  <= w_b_addr;
                     r_dmem_wdata <= r_a;
                     r_state      <= S_MEM;
                  end
                  OP_BEQZ: begin
                     r_pc       <= w_ula_zero ? (r_npc + w_sext_a) : r_npc;
                     r_retire   <= 1'b1;
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                  end
                  OP_JR: begin
                     r_pc       <= ADDR_W'(w_ula_y);
                     r_retire   <= 1'b1;
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                  end
                  default: begin
                     r_alu_out <= w_ula_y;
                     r_state   <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_dmem_req <= 1'b0;
                  r_dmem_we  <= 1'b0;
                  if (r_dmem_we) begin
                     r_pc       <= r_npc;
                     r_retire   <= 1'b1;
                     r_imem_req <= 1'b1;
                     r_state    <= S_FETCH;
                  end else begin
                     r_mdr   <= dmem_rdata;
                     r_state <= S_WB;
                  end
               end
            end
            S_WB: begin
               r_rf[w_ra] <= (w_op == OP_LW) ? r_mdr : r_alu_out;
               r_pc       <= r_npc;
               r_retire   <= 1'b1;
               r_imem_req <= 1'b1;
               r_state    <= S_FETCH;
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_pc;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign pc_o       = r_pc;
   assign retire     = r_retire;

endmodule
